// File: rtl/seg7_dec_pkg.sv
// Shared types and constants for the 7-segment capture decoder.
// Segment order is bit0=a .. bit6=g, 1 = segment lit.
package seg7_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } seg7_state_e;

  // Packed table: element [i] is the segment code of hex digit i.
  localparam logic [15:0][6:0] SEG7_CODE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG7_BLANK = 7'h00;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup of a segment pattern to a hex digit.
module seg7_pattern_lookup
  import seg7_dec_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       is_digit_o,
  output logic       is_blank_o,
  output logic [3:0] digit_o
);

  // Search the code table; codes are unique so at most one entry matches.
  always_comb begin
    is_digit_o = 1'b0;
    digit_o    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG7_CODE[i]) begin
        is_digit_o = 1'b1;
        digit_o    = 4'(i);
      end
    end
    is_blank_o = (seg_i == SEG7_BLANK);
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Receive side of the 7-segment loopback path: stability filter, pattern decode,
// illegal-code flagging and accept counting.
// Optional feature: define SEG7_DEC_SEQ_CHECK_EN to enable the count-up sequence checker.
module seg7_capture_decoder
  import seg7_dec_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             clr_err,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] accept_count
);

  localparam int unsigned StabW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [StabW-1:0] StableVal = StabW'(STABLE_CYCLES);

  seg7_state_e      state_q, state_d;
  logic [6:0]       seg_q, seg_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  logic             lk_is_digit;
  logic             lk_is_blank;
  logic [3:0]       lk_digit;

  seg7_pattern_lookup u_lookup (
    .seg_i      (seg_q),
    .is_digit_o (lk_is_digit),
    .is_blank_o (lk_is_blank),
    .digit_o    (lk_digit)
  );

  // Filter counter, FSM next state and event generation.
  always_comb begin
    seg_d    = seg_in;
    stab_d   = (seg_in != seg_q) ? StabW'(1) :
               (stab_q == StableVal) ? stab_q : stab_q + 1'b1;
    state_d  = state_q;
    digit_d  = digit_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    count_d  = count_q;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stab_d  = StabW'(1);
        state_d = TRACK;
      end
      TRACK: begin
        if (stab_q == StableVal) begin
          state_d = LOCKED;
          if (lk_is_digit) begin
            accept  = 1'b1;
            digit_d = lk_digit;
            valid_d = 1'b1;
            count_d = count_q + 1'b1;
          end else if (!lk_is_blank) begin
            perr_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        // A change on the evaluation edge leaves stab below the threshold; re-track it.
        if ((seg_in != seg_q) || (stab_q != StableVal)) begin
          state_d = TRACK;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      seg_q    <= 7'd0;
      stab_q   <= '0;
      digit_q  <= 4'd0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      locked_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      stab_q   <= stab_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      locked_q <= locked_d;
      count_q  <= count_d;
    end
  end

  assign digit_out    = digit_q;
  assign digit_valid  = valid_q;
  assign pattern_err  = perr_q;
  assign locked       = locked_q;
  assign accept_count = count_q;

`ifdef SEG7_DEC_SEQ_CHECK_EN
  logic [3:0] last_q, last_d;
  logic       have_ref_q, have_ref_d;
  logic       seq_err_q, seq_err_d;

  // Sequence reference; an error in the same cycle as clr_err still wins.
  always_comb begin
    seq_err_d  = clr_err ? 1'b0 : seq_err_q;
    have_ref_d = clr_err ? 1'b0 : have_ref_q;
    last_d     = last_q;
    if (accept) begin
      if (have_ref_q && (lk_digit != last_q + 4'd1)) begin
        seq_err_d = 1'b1;
      end
      last_d     = lk_digit;
      have_ref_d = 1'b1;
    end
  end

  // Sequence checker registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= 4'd0;
      have_ref_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      have_ref_q <= have_ref_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder (STABLE_CYCLES=4): a run-length model checked every
// cycle plus directed literal expectations. Honours SEG7_DEC_SEQ_CHECK_EN.
module tb_seg7_capture_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = 7'h3F;
  logic       clr_err = 1'b0;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       pattern_err;
  logic       seq_err;
  logic       locked;
  logic [7:0] accept_count;

  int checks = 0;
  int errors = 0;
  int dv_seen = 0;
  int pe_seen = 0;

  seg7_capture_decoder #(
    .STABLE_CYCLES (STABLE),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .clr_err      (clr_err),
    .digit_out    (digit_out),
    .digit_valid  (digit_valid),
    .pattern_err  (pattern_err),
    .seq_err      (seq_err),
    .locked       (locked),
    .accept_count (accept_count)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: current run of identical samples and whether it already produced an event.
  logic [6:0] m_cur;
  int         m_run;
  bit         m_fired;
  bit         m_dv, m_pe, m_locked, m_seq, m_have;
  logic [3:0] m_digit, m_last;
  logic [7:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0..15 digit, 16 blank, -1 illegal.
  function automatic int decode(input logic [6:0] s);
    if (s == 7'h00) return 16;
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_cur = 7'd0; m_run = 0; m_fired = 0;
    m_dv = 0; m_pe = 0; m_locked = 0; m_seq = 0; m_have = 0;
    m_digit = 4'd0; m_last = 4'd0; m_cnt = 8'd0;
  endtask

  task automatic model_step();
    logic [6:0] s;
    bit         clr;
    bit         acc;
    int         d;
    s   = seg_in;
    clr = clr_err;
    acc = 0;
    d   = 0;
    m_dv = 0;
    m_pe = 0;
    if (m_run >= STABLE && !m_fired) begin
      m_fired  = 1;
      m_locked = 1;
      d = decode(m_cur);
      if (d >= 0 && d < 16) begin
        acc = 1; m_dv = 1; m_digit = 4'(d); m_cnt = m_cnt + 8'd1;
      end else if (d < 0) begin
        m_pe = 1;
      end
    end else begin
      m_locked = m_locked && (s == m_cur) && (m_run >= STABLE);
    end
`ifdef SEG7_DEC_SEQ_CHECK_EN
    begin
      bit had;
      had = m_have;
      if (clr) begin m_seq = 0; m_have = 0; end
      if (acc) begin
        if (had && d != ((int'(m_last) + 1) % 16)) m_seq = 1;
        m_last = 4'(d);
        m_have = 1;
      end
    end
`else
    m_seq = 0;
`endif
    if (m_run != 0 && s == m_cur) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_cur = s; m_run = 1; m_fired = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison and event counting, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("model", {digit_valid, pattern_err, digit_out, locked, seq_err, accept_count},
            {m_dv, m_pe, m_digit, m_locked, m_seq, m_cnt});
      if (digit_valid) dv_seen++;
      if (pattern_err) pe_seen++;
    end
  end

  // Hold a pattern for n cycles; inputs change 2 ns after the falling edge.
  task automatic drive(input logic [6:0] pat, input int n);
    seg_in = pat;
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clear_seen();
    dv_seen = 0;
    pe_seen = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs", {digit_valid, pattern_err, digit_out, locked, seq_err, accept_count},
          16'h0);
    reset = 1'b0;

    // 1: latency from reset release with 3F held.
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k < 5) check("t1_no_early_valid", digit_valid, 0);
    end
    check("t1_valid", digit_valid, 1);
    check("t1_digit", digit_out, 4'h0);
    check("t1_count", accept_count, 8'd1);
    check("t1_locked", locked, 1);
    @(negedge clk);
    #2;
    drive(7'h3F, 4);

    // 2: short 06 is filtered, 5B accepted once.
    clear_seen();
    drive(7'h06, 3);
    drive(7'h5B, 12);
    check("t2_pulses", dv_seen, 1);
    check("t2_digit", digit_out, 4'h2);
    check("t2_count", accept_count, 8'd2);

    // 3: illegal pattern.
    clear_seen();
    drive(7'h55, 10);
    check("t3_perr", pe_seen, 1);
    check("t3_no_valid", dv_seen, 0);
    check("t3_digit_kept", digit_out, 4'h2);
    check("t3_locked", locked, 1);

    // 4: count-up sequence E F 0 1 then a skip to 3.
    clr_err = 1'b1;
    drive(7'h55, 1);
    clr_err = 1'b0;
    check("t4_clr", seq_err, 0);
    clear_seen();
    drive(7'h79, 8);
    drive(7'h71, 8);
    drive(7'h3F, 8);
    drive(7'h06, 8);
    check("t4_pulses", dv_seen, 4);
    check("t4_seq_ok", seq_err, 0);
    drive(7'h4F, 8);
`ifdef SEG7_DEC_SEQ_CHECK_EN
    check("t4_seq_skip", seq_err, 1);
`else
    check("t4_seq_off", seq_err, 0);
`endif
    clr_err = 1'b1;
    drive(7'h4F, 1);
    clr_err = 1'b0;
    check("t4_seq_cleared", seq_err, 0);

    // 5: blank between 4 and 5.
    clear_seen();
    drive(7'h66, 8);
    drive(7'h00, 8);
    drive(7'h6D, 8);
    check("t5_pulses", dv_seen, 2);
    check("t5_no_perr", pe_seen, 0);
    check("t5_seq", seq_err, 0);
    check("t5_count", accept_count, 8'd9);
    check("t5_digit", digit_out, 4'h5);

    // 6: reset while tracking with stab_cnt=2.
    drive(7'h7D, 2);
    reset = 1'b1;
    #1;
    check("t6_reset_now", {digit_valid, pattern_err, digit_out, locked, seq_err, accept_count},
          16'h0);
    seg_in = 7'h07;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    clear_seen();
    drive(7'h07, 8);
    check("t6_pulses", dv_seen, 1);
    check("t6_digit", digit_out, 4'h7);
    check("t6_count", accept_count, 8'd1);

    // 7: one-cycle glitch while locked; the held pattern is re-accepted, glitch ignored.
    clear_seen();
    drive(7'h3F, 1);
    drive(7'h07, 8);
    check("t7_pulses", dv_seen, 1);
    check("t7_digit", digit_out, 4'h7);
    check("t7_count", accept_count, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
